// File: rtl/sort_stream_dma.sv
// sort_stream_dma: stream-side driver for the sort accelerator.
// Transmits a CPU-loaded source buffer as one AXI-Stream packet into the
// sorter and collects the same number of result words into a result buffer
// that the CPU reads back.
module sort_stream_dma #(
    parameter int pDATA_WIDTH = 32,
    parameter int pLEN        = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [3:0]             cfg_addr,
    input  logic [pDATA_WIDTH-1:0] cfg_wdata,
    input  logic [3:0]             cfg_raddr,
    output logic [pDATA_WIDTH-1:0] cfg_rdata,
    input  logic                   ap_start,
    output logic                   ap_idle,
    output logic                   ap_done,
    output logic                   m_tvalid,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    input  logic                   m_tready,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    output logic                   s_tready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_RECV = 2'd2;

    localparam logic [3:0] LEN_C  = 4'(pLEN);
    localparam logic [3:0] LAST_C = 4'(pLEN - 1);

    logic [1:0]             state_q, state_d;
    logic [3:0]             tx_cnt_q, tx_cnt_d;
    logic [3:0]             rx_cnt_q, rx_cnt_d;
    logic                   done_q, done_d;

    // Sized to the full 4-bit index space; entries at or above pLEN are never
    // written, stay at reset value and read back as 0.
    logic [pDATA_WIDTH-1:0] src_buf_q [16];
    logic [pDATA_WIDTH-1:0] res_buf_q [16];

    logic                   m_hs;
    logic                   s_hs;
    logic                   src_we;
    logic                   tx_last;

    // Outputs are decoded from registered state, so they react to reset
    // asynchronously and stay stable between handshakes.
    assign ap_idle   = (state_q == S_IDLE);
    assign ap_done   = done_q;
    assign m_tvalid  = (state_q == S_SEND);
    assign tx_last   = (tx_cnt_q == LAST_C);
    assign m_tlast   = m_tvalid && tx_last;
    assign m_tdata   = m_tvalid ? src_buf_q[tx_cnt_q] : '0;
    assign s_tready  = (state_q != S_IDLE) && (rx_cnt_q < LEN_C);
    assign cfg_rdata = (cfg_raddr < LEN_C) ? res_buf_q[cfg_raddr] : '0;

    assign m_hs   = m_tvalid && m_tready;
    assign s_hs   = s_tvalid && s_tready;
    assign src_we = ap_idle && cfg_we && (cfg_addr < LEN_C);

    // Next-state logic for the control FSM, beat counters and done flag.
    always_comb begin
        state_d  = state_q;
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        done_d   = done_q;

        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    state_d  = S_SEND;
                    tx_cnt_d = '0;
                    rx_cnt_d = '0;
                    done_d   = 1'b0;
                end
            end
            S_SEND: begin
                if (m_hs) begin
                    tx_cnt_d = tx_cnt_q + 4'd1;
                    if (tx_last) begin
                        state_d = S_RECV;
                    end
                end
            end
            default: ;
        endcase

        // Results may arrive while still sending, so capture counts in both
        // busy states.
        if (s_hs) begin
            rx_cnt_d = rx_cnt_q + 4'd1;
        end

        // Completion needs the whole packet out and all results in; if the
        // results finished first, finish on the last outgoing beat instead.
        if ((state_q == S_RECV || (state_q == S_SEND && m_hs && tx_last))
            && rx_cnt_d == LEN_C) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            done_q   <= done_d;
        end
    end

    // Source buffer written by the CPU only when idle; result buffer written
    // on each slave handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) begin
                src_buf_q[i] <= '0;
                res_buf_q[i] <= '0;
            end
        end else begin
            if (src_we) begin
                src_buf_q[cfg_addr] <= cfg_wdata;
            end
            if (s_hs) begin
                res_buf_q[rx_cnt_q] <= s_tdata;
            end
        end
    end

endmodule
